// File: rtl/window_controller.sv
// Register-window controller: validates SAVE/RESTORE against the window invalid mask and updates cwp/wim.
// Optional macro WINDOW_TRAP_COUNT_EN adds a saturating 8-bit trap_count output.
module window_controller (
   input  logic       Clk,
   input  logic       Clr,
   input  logic       req_valid,
   input  logic [1:0] req_op,
   input  logic [3:0] req_data,
   output logic       req_ready,
   output logic       done,
   output logic       trap,
   output logic [1:0] trap_type,
   output logic [1:0] cwp,
   output logic [3:0] wim,
   output logic       rf_busy,
   output logic [1:0] fsm_state
`ifdef WINDOW_TRAP_COUNT_EN
   ,
   output logic [7:0] trap_count
`endif
);

   localparam logic [1:0] OP_SAVE    = 2'b00;
   localparam logic [1:0] OP_RESTORE = 2'b01;
   localparam logic [1:0] OP_WRCWP   = 2'b10;
   localparam logic [1:0] OP_WRWIM   = 2'b11;

   localparam logic [1:0] TT_NONE      = 2'b00;
   localparam logic [1:0] TT_OVERFLOW  = 2'b01;
   localparam logic [1:0] TT_UNDERFLOW = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      UPDATE = 2'd2,
      TRAP   = 2'd3
   } state_e;

   state_e     state;
   state_e     state_next;
   logic [1:0] op_q;
   logic [3:0] data_q;
   logic [1:0] new_cwp;
   logic       is_shift;
   logic       accept;

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready is high only in IDLE, and req_op /
   // req_data are captured on that edge so the requester may change them
   // immediately afterwards.
   assign accept    = req_valid & req_ready;
   assign fsm_state = state;

   assign is_shift = (op_q == OP_SAVE) || (op_q == OP_RESTORE);

   always_comb begin
      new_cwp = cwp;
      if (op_q == OP_SAVE) begin
         new_cwp = cwp - 2'd1;
      end else if (op_q == OP_RESTORE) begin
         new_cwp = cwp + 2'd1;
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      done       = 1'b0;
      trap       = 1'b0;
      rf_busy    = 1'b1;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            rf_busy   = 1'b0;
            if (req_valid) begin
               state_next = CHECK;
            end
         end
         CHECK: begin
            if (is_shift && wim[new_cwp]) begin
               state_next = TRAP;
            end else begin
               state_next = UPDATE;
            end
         end
         UPDATE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         TRAP: begin
            trap       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         op_q   <= OP_SAVE;
         data_q <= 4'b0000;
      end else if (accept) begin
         op_q   <= req_op;
         data_q <= req_data;
      end
   end

   // cwp cannot move between CHECK and UPDATE, so new_cwp is still valid here.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         cwp <= 2'b00;
         wim <= 4'b0000;
      end else if (state == UPDATE) begin
         case (op_q)
            OP_SAVE, OP_RESTORE: cwp <= new_cwp;
            OP_WRCWP:            cwp <= data_q[1:0];
            OP_WRWIM:            wim <= data_q;
            default:             cwp <= cwp;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         trap_type <= TT_NONE;
      end else if (state == TRAP) begin
         trap_type <= (op_q == OP_SAVE) ? TT_OVERFLOW : TT_UNDERFLOW;
      end
   end

`ifdef WINDOW_TRAP_COUNT_EN
   always_ff @(posedge Clk) begin
      if (Clr) begin
         trap_count <= 8'd0;
      end else if ((state == TRAP) && (trap_count != 8'hFF)) begin
         trap_count <= trap_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_window_controller.sv
// Self-checking bench for window_controller: directed vector table, multi-cycle
// corner sequences and randomized requests against a transaction-level model.
module tb_window_controller;

   logic       Clk;
   logic       Clr;
   logic       req_valid;
   logic [1:0] req_op;
   logic [3:0] req_data;
   logic       req_ready;
   logic       done;
   logic       trap;
   logic [1:0] trap_type;
   logic [1:0] cwp;
   logic [3:0] wim;
   logic       rf_busy;
   logic [1:0] fsm_state;
`ifdef WINDOW_TRAP_COUNT_EN
   logic [7:0] trap_count;
`endif

   window_controller dut (
      .Clk       (Clk),
      .Clr       (Clr),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_data  (req_data),
      .req_ready (req_ready),
      .done      (done),
      .trap      (trap),
      .trap_type (trap_type),
      .cwp       (cwp),
      .wim       (wim),
      .rf_busy   (rf_busy),
      .fsm_state (fsm_state)
`ifdef WINDOW_TRAP_COUNT_EN
      ,
      .trap_count(trap_count)
`endif
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_cmp = 0;
   int n_bad = 0;

   // transaction-level model state
   int m_cwp;
   int m_wim;
   int m_tt;
   int m_cnt;

   typedef struct {
      logic [1:0] op;
      logic [3:0] data;
      logic       exp_trap;
      logic [1:0] exp_tt;
      logic [1:0] exp_cwp;
      logic [3:0] exp_wim;
   } vec_t;

   vec_t vecs[18];

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cwp = 0;
      m_wim = 0;
      m_tt  = 0;
      m_cnt = 0;
   endtask

   task automatic do_reset();
      Clr       = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_data  = 4'b0000;
      step();
      step();
      Clr = 1'b0;
      model_reset();
      check("rst_ready", 8'(req_ready), 8'd1);
      check("rst_done", 8'(done), 8'd0);
      check("rst_trap", 8'(trap), 8'd0);
      check("rst_tt", 8'(trap_type), 8'd0);
      check("rst_cwp", 8'(cwp), 8'd0);
      check("rst_wim", 8'(wim), 8'd0);
      check("rst_busy", 8'(rf_busy), 8'd0);
`ifdef WINDOW_TRAP_COUNT_EN
      check("rst_cnt", trap_count, 8'd0);
`endif
   endtask

   // One request from IDLE, checked phase by phase with explicit expectations.
   task automatic do_req(input logic [1:0] op, input logic [3:0] data, input logic e_trap,
                         input logic [1:0] e_tt, input logic [1:0] e_cwp, input logic [3:0] e_wim);
      check("pre_ready", 8'(req_ready), 8'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_data  = data;
      step();
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_data  = 4'($urandom);
      check("chk_ready", 8'(req_ready), 8'd0);
      check("chk_busy", 8'(rf_busy), 8'd1);
      check("chk_pulses", {6'd0, done, trap}, 8'd0);
      step();
      check("res_done", 8'(done), 8'(!e_trap));
      check("res_trap", 8'(trap), 8'(e_trap));
      check("res_busy", 8'(rf_busy), 8'd1);
      if (e_trap && m_cnt < 255) m_cnt++;
      step();
      check("end_cwp", 8'(cwp), 8'(e_cwp));
      check("end_wim", 8'(wim), 8'(e_wim));
      check("end_tt", 8'(trap_type), 8'(e_tt));
      check("end_ready", 8'(req_ready), 8'd1);
      check("end_pulses", {5'd0, rf_busy, done, trap}, 8'd0);
`ifdef WINDOW_TRAP_COUNT_EN
      check("end_cnt", trap_count, 8'(m_cnt));
`endif
      m_cwp = int'(e_cwp);
      m_wim = int'(e_wim);
      m_tt  = int'(e_tt);
   endtask

   // Expected outcome computed from the window rules with plain arithmetic.
   task automatic model_req(input logic [1:0] op, input logic [3:0] data);
      int  tgt;
      bit  is_trap;
      int  n_cwp;
      int  n_wim;
      int  n_tt;
      n_cwp   = m_cwp;
      n_wim   = m_wim;
      n_tt    = m_tt;
      tgt     = (op == 2'b00) ? (m_cwp + 3) % 4 : (m_cwp + 1) % 4;
      is_trap = (op <= 2'b01) && (((m_wim >> tgt) & 1) == 1);
      if (is_trap) begin
         n_tt = (op == 2'b00) ? 1 : 2;
      end else begin
         case (op)
            2'b00, 2'b01: n_cwp = tgt;
            2'b10:        n_cwp = int'(data) % 4;
            default:      n_wim = int'(data);
         endcase
      end
      do_req(op, data, is_trap, 2'(n_tt), 2'(n_cwp), 4'(n_wim));
   endtask

   initial begin
      vecs[0]  = '{2'b00, 4'h0, 1'b0, 2'b00, 2'd3, 4'h0};
      vecs[1]  = '{2'b01, 4'h0, 1'b0, 2'b00, 2'd0, 4'h0};
      vecs[2]  = '{2'b11, 4'h4, 1'b0, 2'b00, 2'd0, 4'h4};
      vecs[3]  = '{2'b10, 4'h3, 1'b0, 2'b00, 2'd3, 4'h4};
      vecs[4]  = '{2'b01, 4'h0, 1'b0, 2'b00, 2'd0, 4'h4};
      vecs[5]  = '{2'b10, 4'h1, 1'b0, 2'b00, 2'd1, 4'h4};
      vecs[6]  = '{2'b00, 4'h0, 1'b0, 2'b00, 2'd0, 4'h4};
      vecs[7]  = '{2'b10, 4'hF, 1'b0, 2'b00, 2'd3, 4'h4};
      vecs[8]  = '{2'b00, 4'h0, 1'b1, 2'b01, 2'd3, 4'h4};
      vecs[9]  = '{2'b11, 4'h1, 1'b0, 2'b01, 2'd3, 4'h1};
      vecs[10] = '{2'b10, 4'h1, 1'b0, 2'b01, 2'd1, 4'h1};
      vecs[11] = '{2'b01, 4'h0, 1'b0, 2'b01, 2'd2, 4'h1};
      vecs[12] = '{2'b10, 4'h1, 1'b0, 2'b01, 2'd1, 4'h1};
      vecs[13] = '{2'b00, 4'h0, 1'b1, 2'b01, 2'd1, 4'h1};
      vecs[14] = '{2'b10, 4'h3, 1'b0, 2'b01, 2'd3, 4'h1};
      vecs[15] = '{2'b01, 4'h0, 1'b1, 2'b10, 2'd3, 4'h1};
      vecs[16] = '{2'b11, 4'h8, 1'b0, 2'b10, 2'd3, 4'h8};
      vecs[17] = '{2'b00, 4'h0, 1'b0, 2'b10, 2'd2, 4'h8};

      do_reset();

      // directed vector table
      for (int i = 0; i < 18; i++) begin
         do_req(vecs[i].op, vecs[i].data, vecs[i].exp_trap, vecs[i].exp_tt,
                vecs[i].exp_cwp, vecs[i].exp_wim);
      end

      // back-to-back: req_valid held high, alternating SAVE/RESTORE
      model_req(2'b11, 4'h0);
      req_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k % 3 == 0) begin
            req_op = ((k / 3) % 2 == 1) ? 2'b01 : 2'b00;
            check("b2b_cwp", 8'(cwp), ((k / 3) % 2 == 1) ? 8'((m_cwp + 3) % 4) : 8'(m_cwp));
         end
         check("b2b_ready", 8'(req_ready), 8'(k % 3 == 0));
         check("b2b_busy", 8'(rf_busy), 8'(k % 3 != 0));
         check("b2b_done", 8'(done), 8'(k % 3 == 2));
         check("b2b_trap", 8'(trap), 8'd0);
         step();
      end
      req_valid = 1'b0;
      check("b2b_final_cwp", 8'(cwp), 8'(m_cwp));
      check("b2b_final_ready", 8'(req_ready), 8'd1);

      // reset during CHECK of a SAVE from cwp=2 abandons the request
      model_req(2'b11, 4'h4);
      model_req(2'b10, 4'h2);
      req_valid = 1'b1;
      req_op    = 2'b00;
      step();
      req_valid = 1'b0;
      Clr       = 1'b1;
      check("clr_chk_busy", 8'(rf_busy), 8'd1);
      step();
      Clr = 1'b0;
      model_reset();
      check("clr_ready", 8'(req_ready), 8'd1);
      check("clr_pulses", {6'd0, done, trap}, 8'd0);
      check("clr_cwp", 8'(cwp), 8'd0);
      check("clr_wim", 8'(wim), 8'd0);
      check("clr_tt", 8'(trap_type), 8'd0);
      check("clr_busy", 8'(rf_busy), 8'd0);
      step();
      check("clr_late_pulses", {6'd0, done, trap}, 8'd0);
      check("clr_late_cwp", 8'(cwp), 8'd0);

      // randomized requests with random idle gaps
      for (int r = 0; r < 200; r++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            step();
            check("gap_pulses", {6'd0, done, trap}, 8'd0);
         end
         model_req(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      end

`ifdef WINDOW_TRAP_COUNT_EN
      // trap counter saturation and clear
      model_req(2'b11, 4'hF);
      for (int t = 0; t < 260; t++) begin
         model_req(2'b00, 4'h0);
      end
      check("cnt_sat", trap_count, 8'd255);
      Clr = 1'b1;
      step();
      Clr = 1'b0;
      model_reset();
      check("cnt_clr", trap_count, 8'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
